mem_port_arbiter: RTL and testbench
===================================

// Module: mem_port_arbiter
// PURPOSE
//  Shares the single-port MemUnit between instruction fetch (IF, read-only) and load/store (LS, read/write).
//  Each requester has a valid/ready request channel and a valid/ready response channel.
//  Accepts one access at a time and drives the MemUnit _we/_data/_vptr inputs for it.
//  Registers MemUnit value_ as the response. Sits between the pipeline front/back ends and MemUnit.
// PARAMETERS
//  DATA_W       32  data and virtual-address width
//  MEM_LAT      1   cycles from mem_vptr_ valid to _mem_value valid (>=1)
//  STARVE_LIMIT 4   consecutive LS grants with IF waiting before IF is forced (>=1)
// PORTS
//  _clk           in   1       clock, all state on posedge
//  _reset         in   1       asynchronous, active-low reset
//  _if_req_valid  in   1       IF read request
//  _if_vptr       in   DATA_W  IF virtual address
//  if_req_ready_  out  1       IF request accepted this cycle (valid&ready)
//  if_rsp_valid_  out  1       IF response valid
//  if_rsp_data_   out  DATA_W  IF read data
//  _if_rsp_ready  in   1       IF consumes response
//  _ls_req_valid  in   1       LS request
//  _ls_we         in   1       LS write (1) / read (0)
//  _ls_vptr       in   DATA_W  LS virtual address
//  _ls_data       in   DATA_W  LS write data
//  ls_req_ready_  out  1       LS request accepted this cycle
//  ls_rsp_valid_  out  1       LS response valid
//  ls_rsp_data_   out  DATA_W  LS read data, or write data echoed for writes
//  _ls_rsp_ready  in   1       LS consumes response
//  mem_we_        out  1       to MemUnit _we
//  mem_vptr_      out  DATA_W  to MemUnit _vptr
//  mem_data_      out  DATA_W  to MemUnit _data
//  _mem_value     in   DATA_W  from MemUnit value_
//  busy_          out  1       state != IDLE
// BEHAVIOUR
//  Reset: state=IDLE; starve_cnt=0; all outputs 0, including mem_vptr_ and mem_data_.
//  FSM IDLE -> ACCESS -> RESP -> IDLE.
//  IDLE: arbitrate combinationally and assert the winner's req_ready_ in the same cycle.
//    On handshake, latch owner, we, vptr and data, set cnt=MEM_LAT, and go to ACCESS.
//    With no valid requester, stay in IDLE.
//  Arbitration: LS wins by default. IF wins when LS is not valid, or when IF is valid and starve_cnt==STARVE_LIMIT.
//    IF grant: starve_cnt=0.
//    LS grant while IF is valid: starve_cnt+1, saturating at STARVE_LIMIT.
//    LS grant while IF is idle: starve_cnt=0.
//  ACCESS: mem_vptr_ and mem_data_ = latched values; cnt decrements each cycle.
//    mem_we_=1 only in the final ACCESS cycle (cnt==1), and only when latched we=1.
//    At the end of the final cycle: rsp_data = we ? latched data : _mem_value; go to RESP.
//  RESP: owner's rsp_valid_=1 with stable rsp_data_ until the owner's _rsp_ready=1, then IDLE.
//    A response completes and the next accept occurs in separate cycles (no IDLE bypass).
//  Latency: accept at cycle T; mem_vptr_ valid T+1..T+MEM_LAT; rsp_valid_ from T+MEM_LAT+1.
//    Peak throughput: one access per MEM_LAT+2 cycles.
//  Outside ACCESS: mem_we_=0; mem_vptr_ and mem_data_ hold their last values.
//  Non-owner req_ready_ and rsp_valid_ are always 0. req_ready_ is 0 outside IDLE.
//  A requester may drop valid before ready without side effects.
//  Requester fields are sampled only on the handshake cycle.
//  Reset mid-access (async): mem_we_ falls immediately; the in-flight access is discarded and no response is issued.
// CONFIGURATION
//  MEM_ARB_PERF_EN defined: adds outputs perf_if_grants_, perf_ls_grants_ and perf_conflicts_ (each 32 bit).
//    The grant counters increment per IF/LS grant.
//    perf_conflicts_ increments on each IF-cycle where both valids are high in IDLE.
//    All three counters wrap at 2^32 and are cleared by reset.
//  MEM_ARB_PERF_EN undefined: these ports and their logic are absent; behaviour is otherwise identical.
// TESTING (MEM_LAT=1, STARVE_LIMIT=4 unless stated)
//  1 IF read 0x10, mem holds 0xDEADBEEF -> if_req_ready_@T, mem_vptr_=0x10@T+1.
//    if_rsp_valid_ with 0xDEADBEEF @T+2.
//  2 LS write 0x20 <- 0x12345678 -> mem_we_=1 for exactly one cycle; ls_rsp_data_=0x12345678.
//    A following IF read of 0x20 returns 0x12345678.
//  3 Both valids held high, rsp_ready=1 -> grant order LS,LS,LS,LS,IF,LS,LS,LS,LS,IF.
//  4 _ls_rsp_ready=0 for 5 cycles in RESP -> ls_rsp_valid_ and data stable, busy_=1.
//    Both req_ready_=0 throughout; IDLE is reached the cycle after ready rises.
//  5 _reset low during ACCESS of a write -> mem_we_ falls asynchronously; all outputs 0.
//    No rsp_valid_ after release.
//  6 MEM_LAT=3, IF read -> mem_vptr_ held 3 cycles; rsp_valid_ @T+4.
//    With MEM_ARB_PERF_EN after test 3: ls=8, if=2, conflicts=10.

Source files
------------

// File: rtl/mem_port_arbiter.sv
// rtl/mem_port_arbiter.sv - shares the single-port MemUnit between instruction fetch and load/store
// Optional feature macro: MEM_ARB_PERF_EN (adds grant/conflict performance counters)
module mem_port_arbiter #(
   parameter int DATA_W       = 32,
   parameter int MEM_LAT      = 1,
   parameter int STARVE_LIMIT = 4
) (
   input  logic              _clk,
   input  logic              _reset,
   // instruction fetch: read-only requester
   input  logic              _if_req_valid,
   input  logic [DATA_W-1:0] _if_vptr,
   output logic              if_req_ready_,
   output logic              if_rsp_valid_,
   output logic [DATA_W-1:0] if_rsp_data_,
   input  logic              _if_rsp_ready,
   // load/store: read/write requester
   input  logic              _ls_req_valid,
   input  logic              _ls_we,
   input  logic [DATA_W-1:0] _ls_vptr,
   input  logic [DATA_W-1:0] _ls_data,
   output logic              ls_req_ready_,
   output logic              ls_rsp_valid_,
   output logic [DATA_W-1:0] ls_rsp_data_,
   input  logic              _ls_rsp_ready,
   // MemUnit side
   output logic              mem_we_,
   output logic [DATA_W-1:0] mem_vptr_,
   output logic [DATA_W-1:0] mem_data_,
   input  logic [DATA_W-1:0] _mem_value,
   output logic              busy_
`ifdef MEM_ARB_PERF_EN
   ,
   output logic [31:0]       perf_if_grants_,
   output logic [31:0]       perf_ls_grants_,
   output logic [31:0]       perf_conflicts_
`endif
);

   localparam int CNT_W = $clog2(MEM_LAT + 1);
   localparam int SW    = $clog2(STARVE_LIMIT + 1);
   localparam logic [CNT_W-1:0] CNT_LOAD   = CNT_W'(MEM_LAT);
   localparam logic [CNT_W-1:0] CNT_FINAL  = CNT_W'(1);
   localparam logic [SW-1:0]    STARVE_MAX = SW'(STARVE_LIMIT);

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      ACCESS = 2'd1,
      RESP   = 2'd2
   } state_t;

   state_t            state;
   logic              owner_ls;     // 1: LS owns the current access, 0: IF
   logic              we_q;
   logic [CNT_W-1:0]  cnt;
   logic [SW-1:0]     starve_cnt;
   logic [DATA_W-1:0] rsp_data;

   logic in_idle;
   logic in_access;
   logic in_resp;
   logic if_win;
   logic ls_win;
   logic accept;
   logic final_cycle;
   logic rsp_done;

   assign in_idle   = (state == IDLE);
   assign in_access = (state == ACCESS);
   assign in_resp   = (state == RESP);

   // LS has priority unless IF has been passed over STARVE_LIMIT times in a row
   assign if_win = _if_req_valid && (!_ls_req_valid || (starve_cnt == STARVE_MAX));
   assign ls_win = _ls_req_valid && !if_win;

   // ready is combinational so the winner is accepted in the same IDLE cycle
   assign if_req_ready_ = in_idle && if_win;
   assign ls_req_ready_ = in_idle && ls_win;
   assign accept        = if_req_ready_ || ls_req_ready_;

   // the write strobe lasts only the last ACCESS cycle; decoded from reset-cleared state so it drops asynchronously
   assign final_cycle = in_access && (cnt == CNT_FINAL);
   assign mem_we_     = final_cycle && we_q;

   assign if_rsp_valid_ = in_resp && !owner_ls;
   assign ls_rsp_valid_ = in_resp && owner_ls;
   assign if_rsp_data_  = rsp_data;
   assign ls_rsp_data_  = rsp_data;
   assign rsp_done      = owner_ls ? _ls_rsp_ready : _if_rsp_ready;

   assign busy_ = !in_idle;

   // access FSM: latch request on handshake, drive MemUnit for MEM_LAT cycles, hold response until consumed
   always_ff @(posedge _clk or negedge _reset) begin
      if (!_reset) begin
         state      <= IDLE;
         owner_ls   <= 1'b0;
         we_q       <= 1'b0;
         cnt        <= '0;
         starve_cnt <= '0;
         rsp_data   <= '0;
         mem_vptr_  <= '0;
         mem_data_  <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (accept) begin
                  owner_ls  <= ls_win;
                  we_q      <= ls_win && _ls_we;
                  mem_vptr_ <= ls_win ? _ls_vptr : _if_vptr;
                  // IF carries no write data; drive zeros rather than a stale LS value
                  mem_data_ <= ls_win ? _ls_data : '0;
                  cnt       <= CNT_LOAD;
                  state     <= ACCESS;
                  if (if_win) begin
                     starve_cnt <= '0;
                  end else if (_if_req_valid) begin
                     if (starve_cnt != STARVE_MAX) begin
                        starve_cnt <= starve_cnt + SW'(1);
                     end
                  end else begin
                     starve_cnt <= '0;
                  end
               end
            end
            ACCESS: begin
               cnt <= cnt - CNT_W'(1);
               if (cnt == CNT_FINAL) begin
                  // writes echo their own data; reads capture the MemUnit value
                  rsp_data <= we_q ? mem_data_ : _mem_value;
                  state    <= RESP;
               end
            end
            RESP: begin
               if (rsp_done) begin
                  state <= IDLE;
               end
            end
            default: begin
               state <= IDLE;
            end
         endcase
      end
   end

`ifdef MEM_ARB_PERF_EN
   // performance counters: grants per requester and IDLE cycles where both request, wrapping at 2^32
   always_ff @(posedge _clk or negedge _reset) begin
      if (!_reset) begin
         perf_if_grants_ <= '0;
         perf_ls_grants_ <= '0;
         perf_conflicts_ <= '0;
      end else begin
         if (if_req_ready_) begin
            perf_if_grants_ <= perf_if_grants_ + 32'd1;
         end
         if (ls_req_ready_) begin
            perf_ls_grants_ <= perf_ls_grants_ + 32'd1;
         end
         if (in_idle && _if_req_valid && _ls_req_valid) begin
            perf_conflicts_ <= perf_conflicts_ + 32'd1;
         end
      end
   end
`endif

endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb/tb_mem_port_arbiter.sv - directed self-checking bench for mem_port_arbiter
module tb_mem_port_arbiter;

   logic        clk = 1'b0;
   logic        rst_n;

   logic        if_req_valid, if_rsp_ready, ls_req_valid, ls_we, ls_rsp_ready;
   logic [31:0] if_vptr, ls_vptr, ls_data;
   logic        if_req_ready, if_rsp_valid, ls_req_ready, ls_rsp_valid, mem_we, busy;
   logic [31:0] if_rsp_data, ls_rsp_data, mem_vptr, mem_data, mem_value;

   logic        b_if_req_valid;
   logic [31:0] b_if_vptr;
   logic        b_if_req_ready, b_if_rsp_valid, b_ls_req_ready, b_ls_rsp_valid, b_mem_we, b_busy;
   logic [31:0] b_if_rsp_data, b_ls_rsp_data, b_mem_vptr, b_mem_data, b_mem_value;

`ifdef MEM_ARB_PERF_EN
   logic [31:0] perf_if, perf_ls, perf_cf, b_perf_if, b_perf_ls, b_perf_cf;
`endif

   int tests = 0;
   int fails = 0;

   always #5 clk = ~clk;

   mem_port_arbiter #(.DATA_W(32), .MEM_LAT(1), .STARVE_LIMIT(4)) u_dut (
      ._clk(clk), ._reset(rst_n),
      ._if_req_valid(if_req_valid), ._if_vptr(if_vptr), .if_req_ready_(if_req_ready),
      .if_rsp_valid_(if_rsp_valid), .if_rsp_data_(if_rsp_data), ._if_rsp_ready(if_rsp_ready),
      ._ls_req_valid(ls_req_valid), ._ls_we(ls_we), ._ls_vptr(ls_vptr), ._ls_data(ls_data),
      .ls_req_ready_(ls_req_ready), .ls_rsp_valid_(ls_rsp_valid), .ls_rsp_data_(ls_rsp_data),
      ._ls_rsp_ready(ls_rsp_ready),
      .mem_we_(mem_we), .mem_vptr_(mem_vptr), .mem_data_(mem_data), ._mem_value(mem_value),
      .busy_(busy)
`ifdef MEM_ARB_PERF_EN
      , .perf_if_grants_(perf_if), .perf_ls_grants_(perf_ls), .perf_conflicts_(perf_cf)
`endif
   );

   mem_port_arbiter #(.DATA_W(32), .MEM_LAT(3), .STARVE_LIMIT(4)) u_lat3 (
      ._clk(clk), ._reset(rst_n),
      ._if_req_valid(b_if_req_valid), ._if_vptr(b_if_vptr), .if_req_ready_(b_if_req_ready),
      .if_rsp_valid_(b_if_rsp_valid), .if_rsp_data_(b_if_rsp_data), ._if_rsp_ready(1'b1),
      ._ls_req_valid(1'b0), ._ls_we(1'b0), ._ls_vptr(32'h0), ._ls_data(32'h0),
      .ls_req_ready_(b_ls_req_ready), .ls_rsp_valid_(b_ls_rsp_valid), .ls_rsp_data_(b_ls_rsp_data),
      ._ls_rsp_ready(1'b1),
      .mem_we_(b_mem_we), .mem_vptr_(b_mem_vptr), .mem_data_(b_mem_data), ._mem_value(b_mem_value),
      .busy_(b_busy)
`ifdef MEM_ARB_PERF_EN
      , .perf_if_grants_(b_perf_if), .perf_ls_grants_(b_perf_ls), .perf_conflicts_(b_perf_cf)
`endif
   );

   // MemUnit model: unwritten words read back a fixed pattern of their address
   bit [31:0] mem [256];
   bit        wr  [256];

   function automatic logic [31:0] def_word(input logic [7:0] a);
      return (a == 8'h10) ? 32'hDEADBEEF : {24'hC0FFEE, a};
   endfunction

   always @(posedge clk) begin
      if (mem_we) begin
         mem[mem_vptr[7:0]] <= mem_data;
         wr[mem_vptr[7:0]]  <= 1'b1;
      end
   end

   assign mem_value   = wr[mem_vptr[7:0]] ? mem[mem_vptr[7:0]] : def_word(mem_vptr[7:0]);
   assign b_mem_value = def_word(b_mem_vptr[7:0]);

   typedef struct {
      logic        is_ls;
      logic        we;
      logic [31:0] vptr;
      logic [31:0] data;
      logic [31:0] exp;
   } vec_t;

   vec_t vecs [8];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
      end
   endtask

   task automatic pulse_reset();
      @(posedge clk); #1;
      rst_n = 1'b0;
      @(posedge clk); #1;
      rst_n = 1'b1;
   endtask

   // one full access with rsp_ready held high: handshake at T, MemUnit drive at T+1, response at T+2
   task automatic do_access(input vec_t v, input string tag);
      int   n;
      logic got;
      @(posedge clk); #1;
      if (v.is_ls) begin
         ls_req_valid = 1'b1; ls_we = v.we; ls_vptr = v.vptr; ls_data = v.data;
      end else begin
         if_req_valid = 1'b1; if_vptr = v.vptr;
      end
      n = 0; got = 1'b0;
      while (!got && n < 20) begin
         @(negedge clk);
         got = v.is_ls ? ls_req_ready : if_req_ready;
         n++;
      end
      check({tag, " req_ready"}, {31'b0, got}, 32'd1);
      check({tag, " other req_ready"}, {31'b0, v.is_ls ? if_req_ready : ls_req_ready}, 32'd0);
      @(posedge clk); #1;
      if_req_valid = 1'b0; ls_req_valid = 1'b0;
      ls_we = 1'b0; ls_vptr = 32'hFFFF_FFFF; ls_data = 32'hFFFF_FFFF; if_vptr = 32'hFFFF_FFFF;
      if (!got) return;
      @(negedge clk);
      check({tag, " mem_vptr"}, mem_vptr, v.vptr);
      check({tag, " mem_we access"}, {31'b0, mem_we}, {31'b0, v.we});
      check({tag, " rsp early"}, {30'b0, if_rsp_valid, ls_rsp_valid}, 32'd0);
      @(negedge clk);
      check({tag, " rsp_valid"}, {30'b0, if_rsp_valid, ls_rsp_valid}, v.is_ls ? 32'd1 : 32'd2);
      check({tag, " rsp_data"}, v.is_ls ? ls_rsp_data : if_rsp_data, v.exp);
      check({tag, " mem_we after"}, {31'b0, mem_we}, 32'd0);
      @(posedge clk); #1;
   endtask

   initial begin
      int          n;
      int          g;
      logic        seen;
      logic [9:0]  order;
      logic [31:0] held;
      vec_t        v;

      vecs[0] = '{1'b0, 1'b0, 32'h10, 32'h0,        32'hDEADBEEF};
      vecs[1] = '{1'b1, 1'b1, 32'h20, 32'h12345678, 32'h12345678};
      vecs[2] = '{1'b0, 1'b0, 32'h20, 32'h0,        32'h12345678};
      vecs[3] = '{1'b1, 1'b0, 32'h20, 32'h0,        32'h12345678};
      vecs[4] = '{1'b1, 1'b0, 32'h33, 32'h0,        32'hC0FFEE33};
      vecs[5] = '{1'b0, 1'b0, 32'h7F, 32'h0,        32'hC0FFEE7F};
      vecs[6] = '{1'b1, 1'b1, 32'hFF, 32'hA5A5A5A5, 32'hA5A5A5A5};
      vecs[7] = '{1'b1, 1'b0, 32'hFF, 32'h0,        32'hA5A5A5A5};

      rst_n = 1'b0;
      if_req_valid = 1'b0; if_vptr = 32'h0; if_rsp_ready = 1'b1;
      ls_req_valid = 1'b0; ls_we = 1'b0; ls_vptr = 32'h0; ls_data = 32'h0; ls_rsp_ready = 1'b1;
      b_if_req_valid = 1'b0; b_if_vptr = 32'h0;

      // reset state
      repeat (2) @(posedge clk);
      @(negedge clk);
      check("reset busy", {31'b0, busy}, 32'd0);
      check("reset mem_vptr", mem_vptr, 32'd0);
      check("reset mem_data", mem_data, 32'd0);
      check("reset outs", {26'b0, mem_we, if_req_ready, ls_req_ready, if_rsp_valid, ls_rsp_valid, b_busy}, 32'd0);
      @(posedge clk); #1;
      rst_n = 1'b1;

      // table-driven single accesses
      for (int i = 0; i < 8; i++) begin
         do_access(vecs[i], $sformatf("vec%0d", i));
      end

      // sustained contention: LS x4 then forced IF, twice
      pulse_reset();
      @(posedge clk); #1;
      if_req_valid = 1'b1; if_vptr = 32'h10;
      ls_req_valid = 1'b1; ls_we = 1'b0; ls_vptr = 32'h33;
      g = 0; n = 0; order = '0;
      while (g < 10 && n < 300) begin
         @(negedge clk);
         n++;
         if (ls_req_ready) begin
            order[g] = 1'b0; g++;
         end else if (if_req_ready) begin
            order[g] = 1'b1; g++;
         end
      end
      @(posedge clk); #1;
      if_req_valid = 1'b0; ls_req_valid = 1'b0;
      check("arb grant count", g, 32'd10);
      check("arb grant order", {22'b0, order}, 32'h210);
      n = 0;
      while (busy && n < 20) begin
         @(negedge clk); n++;
      end
      check("arb drained", {31'b0, busy}, 32'd0);
`ifdef MEM_ARB_PERF_EN
      check("perf ls grants", perf_ls, 32'd8);
      check("perf if grants", perf_if, 32'd2);
      check("perf conflicts", perf_cf, 32'd10);
`endif

      // response backpressure
      ls_rsp_ready = 1'b0;
      @(posedge clk); #1;
      ls_req_valid = 1'b1; ls_we = 1'b0; ls_vptr = 32'h33;
      n = 0;
      do begin @(negedge clk); n++; end while (!ls_req_ready && n < 20);
      @(posedge clk); #1;
      ls_req_valid = 1'b0;
      n = 0;
      do begin @(negedge clk); n++; end while (!ls_rsp_valid && n < 20);
      check("stall rsp_valid", {31'b0, ls_rsp_valid}, 32'd1);
      held = ls_rsp_data;
      check("stall rsp_data", held, 32'hC0FFEE33);
      if_req_valid = 1'b1; if_vptr = 32'h10;
      for (int k = 0; k < 5; k++) begin
         @(negedge clk);
         check($sformatf("stall%0d valid", k), {31'b0, ls_rsp_valid}, 32'd1);
         check($sformatf("stall%0d data", k), ls_rsp_data, held);
         check($sformatf("stall%0d busy", k), {31'b0, busy}, 32'd1);
         check($sformatf("stall%0d readys", k), {30'b0, if_req_ready, ls_req_ready}, 32'd0);
      end
      if_req_valid = 1'b0;
      @(posedge clk); #1;
      ls_rsp_ready = 1'b1;
      @(negedge clk);
      check("release resp", {30'b0, busy, ls_rsp_valid}, 32'd3);
      @(negedge clk);
      check("release idle", {30'b0, busy, ls_rsp_valid}, 32'd0);

      // asynchronous reset during a write access
      @(posedge clk); #1;
      ls_req_valid = 1'b1; ls_we = 1'b1; ls_vptr = 32'h40; ls_data = 32'h55AA55AA;
      n = 0;
      do begin @(negedge clk); n++; end while (!ls_req_ready && n < 20);
      @(posedge clk); #1;
      ls_req_valid = 1'b0; ls_we = 1'b0;
      @(negedge clk);
      check("abort we before", {31'b0, mem_we}, 32'd1);
      rst_n = 1'b0;
      #1;
      check("abort we", {31'b0, mem_we}, 32'd0);
      check("abort busy", {31'b0, busy}, 32'd0);
      check("abort mem_vptr", mem_vptr, 32'd0);
      check("abort mem_data", mem_data, 32'd0);
      check("abort rsp", ls_rsp_data, 32'd0);
      @(negedge clk);
      rst_n = 1'b1;
      seen = 1'b0;
      repeat (5) begin
         @(negedge clk);
         seen = seen | ls_rsp_valid | if_rsp_valid | busy;
      end
      check("abort no rsp", {31'b0, seen}, 32'd0);
      v = '{1'b0, 1'b0, 32'h40, 32'h0, 32'hC0FFEE40};
      do_access(v, "abort nowrite");

      // MEM_LAT=3 instance
      @(posedge clk); #1;
      b_if_req_valid = 1'b1; b_if_vptr = 32'h10;
      @(negedge clk);
      check("lat3 ready", {31'b0, b_if_req_ready}, 32'd1);
      @(posedge clk); #1;
      b_if_req_valid = 1'b0; b_if_vptr = 32'h0;
      for (int k = 1; k <= 3; k++) begin
         @(negedge clk);
         check($sformatf("lat3 T+%0d vptr", k), b_mem_vptr, 32'h10);
         check($sformatf("lat3 T+%0d rsp", k), {31'b0, b_if_rsp_valid}, 32'd0);
      end
      @(negedge clk);
      check("lat3 T+4 rsp", {31'b0, b_if_rsp_valid}, 32'd1);
      check("lat3 T+4 data", b_if_rsp_data, 32'hDEADBEEF);
      @(negedge clk);
      check("lat3 idle", {31'b0, b_busy}, 32'd0);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
